// File: rtl/tile_mm_pkg.sv
// Shared FSM encoding and derived-width helpers for the tiled matrix-multiply accumulator.
package tile_mm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width = 0;
        while ((longint'(1) << width) < longint'(value)) width = width + 1;
        return width;
    endfunction

    // Full-precision signed product width.
    function automatic int unsigned prod_w(input int unsigned dw_mul);
        return 2 * dw_mul;
    endfunction

    // Dot-sum width: product width plus growth for n_mul terms.
    function automatic int unsigned dot_w(input int unsigned dw_mul, input int unsigned n_mul);
        return prod_w(dw_mul) + clog2(n_mul);
    endfunction

endpackage

// File: rtl/dot_unit.sv
// Combinational N_MUL-element signed dot product at full precision.
module dot_unit
    import tile_mm_pkg::*;
#(
    parameter int unsigned N_MUL  = 16,
    parameter int unsigned DW_MUL = 8,
    localparam int unsigned DOT_W = dot_w(DW_MUL, N_MUL)
) (
    input  logic [DW_MUL*N_MUL-1:0] a,
    input  logic [DW_MUL*N_MUL-1:0] b,
    output logic [DOT_W-1:0]        dot_c
);

    localparam int unsigned PROD_W = prod_w(DW_MUL);

    logic signed [DW_MUL-1:0] op_a;
    logic signed [DW_MUL-1:0] op_b;
    logic signed [PROD_W-1:0] prod;
    logic signed [DOT_W-1:0]  sum;

    always_comb begin
        op_a = '0;
        op_b = '0;
        prod = '0;
        sum  = '0;
        for (int m = 0; m < int'(N_MUL); m++) begin
            op_a = a[m*DW_MUL +: DW_MUL];
            op_b = b[m*DW_MUL +: DW_MUL];
            prod = PROD_W'(op_a) * PROD_W'(op_b);
            sum  = sum + DOT_W'(prod);
        end
    end

    assign dot_c = sum;

endmodule

// File: rtl/tile_mm_acc.sv
// Tiled matrix-multiply accumulator: captures A/B K-tiles, accumulates N_GROUP x N_UNIT dot products.
module tile_mm_acc
    import tile_mm_pkg::*;
#(
    parameter int unsigned N_GROUP  = 16,
    parameter int unsigned N_UNIT   = 16,
    parameter int unsigned N_MUL    = 16,
    parameter int unsigned DW_MUL   = 8,
    parameter int unsigned DW_ADD   = 32,
    parameter int unsigned KW       = 8,
    parameter int unsigned SATURATE = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enable,
    input  logic                               start,
    input  logic [KW-1:0]                      k_tiles,
    input  logic [DW_MUL*N_MUL*N_GROUP-1:0]    in_a,
    input  logic [DW_MUL*N_MUL*N_UNIT-1:0]     in_b,
    input  logic [1:0]                         in_valid,
    output logic [1:0]                         in_ready,
    output logic [DW_ADD*N_GROUP*N_UNIT-1:0]   out,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               busy,
    output logic                               ovf
);

    localparam int unsigned N_CELL = N_GROUP * N_UNIT;
    localparam int unsigned ROW_W  = DW_MUL * N_MUL;
    localparam int unsigned DOT_W  = dot_w(DW_MUL, N_MUL);
    // Wide enough for both operands so a wide dot sum never aliases before the range check.
    localparam int unsigned SUM_W  = ((DOT_W > DW_ADD) ? DOT_W : DW_ADD) + 1;
    localparam int unsigned HI_W   = SUM_W - DW_ADD + 1;

    state_t                        state;
    state_t                        state_nxt;
    logic [KW-1:0]                 k_lim;
    logic [KW-1:0]                 tile_cnt;
    logic [KW-1:0]                 k_eff;
    logic [N_GROUP*ROW_W-1:0]      a_slot;
    logic [N_UNIT*ROW_W-1:0]       b_slot;
    logic                          a_full;
    logic                          b_full;
    logic [N_CELL-1:0][DW_ADD-1:0] acc;
    logic [N_CELL-1:0][DW_ADD-1:0] acc_nxt;
    logic [N_CELL-1:0][DOT_W-1:0]  dot_all;
    logic [N_CELL-1:0]             cell_ovf;
    logic                          fire;
    logic                          last_tile;
    logic                          clear;
    logic                          cap_a;
    logic                          cap_b;

    for (genvar g = 0; g < N_GROUP; g++) begin : gen_row
        for (genvar u = 0; u < N_UNIT; u++) begin : gen_col
            dot_unit #(
                .N_MUL  (N_MUL),
                .DW_MUL (DW_MUL)
            ) u_dot (
                .a     (a_slot[g*ROW_W +: ROW_W]),
                .b     (b_slot[u*ROW_W +: ROW_W]),
                .dot_c (dot_all[g*N_UNIT+u])
            );
        end
    end

    assign k_eff       = (k_tiles == '0) ? KW'(1) : k_tiles;
    assign fire        = enable && (state == ACCUM) && a_full && b_full;
    assign last_tile   = (tile_cnt == (k_lim - KW'(1)));
    assign in_ready[0] = enable && (state == ACCUM) && (!a_full || fire);
    assign in_ready[1] = enable && (state == ACCUM) && (!b_full || fire);
    assign cap_a       = in_valid[0] && in_ready[0];
    assign cap_b       = in_valid[1] && in_ready[1];
    assign out         = acc;

    // Per-cell accumulate with overflow detection and optional clamp.
    logic signed [DW_ADD-1:0] acc_s;
    logic signed [DOT_W-1:0]  dot_s;
    logic signed [SUM_W-1:0]  sum;
    logic [HI_W-1:0]          sum_hi;

    always_comb begin
        acc_nxt  = acc;
        cell_ovf = '0;
        acc_s    = '0;
        dot_s    = '0;
        sum      = '0;
        sum_hi   = '0;
        for (int i = 0; i < int'(N_CELL); i++) begin
            acc_s       = acc[i];
            dot_s       = dot_all[i];
            sum         = SUM_W'(acc_s) + SUM_W'(dot_s);
            sum_hi      = sum[SUM_W-1:DW_ADD-1];
            cell_ovf[i] = !((&sum_hi) || !(|sum_hi));
            if (cell_ovf[i] && (SATURATE != 0)) begin
                acc_nxt[i] = sum[SUM_W-1] ? {1'b1, {(DW_ADD-1){1'b0}}}
                                          : {1'b0, {(DW_ADD-1){1'b1}}};
            end else begin
                acc_nxt[i] = sum[DW_ADD-1:0];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ACCUM;
                    clear     = 1'b1;
                end
            end
            ACCUM: begin
                if (fire && last_tile) state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    clear     = start;
                    state_nxt = start ? ACCUM : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            k_lim     <= KW'(1);
            tile_cnt  <= '0;
            a_slot    <= '0;
            b_slot    <= '0;
            a_full    <= 1'b0;
            b_full    <= 1'b0;
            acc       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (enable) begin
            state     <= state_nxt;
            out_valid <= (state_nxt == DONE);
            busy      <= (state_nxt != IDLE);
            if (clear) begin
                acc      <= '0;
                ovf      <= 1'b0;
                tile_cnt <= '0;
                k_lim    <= k_eff;
            end else if (fire) begin
                acc      <= acc_nxt;
                ovf      <= ovf || (|cell_ovf);
                tile_cnt <= tile_cnt + KW'(1);
            end
            if (cap_a) a_slot <= in_a;
            if (cap_b) b_slot <= in_b;
            // A slot refilled on the fire edge stays full.
            a_full <= cap_a || (a_full && !fire);
            b_full <= cap_b || (b_full && !fire);
        end
    end

endmodule

// File: tb/tb_tile_mm_acc.sv
// Randomized bench for tile_mm_acc: saturating and wrapping instances against an integer reference model.
module tb_tile_mm_acc;

    localparam int unsigned NG  = 2;
    localparam int unsigned NU  = 2;
    localparam int unsigned NM  = 4;
    localparam int unsigned DWM = 8;
    localparam int unsigned DWA = 16;
    localparam int unsigned KWB = 8;
    localparam int unsigned NC  = NG * NU;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 enable;
    logic                 start;
    logic                 out_ready;
    logic [KWB-1:0]       k_tiles;
    logic [DWM*NM*NG-1:0] in_a;
    logic [DWM*NM*NU-1:0] in_b;
    logic [1:0]           in_valid;
    logic [1:0]           in_ready_s;
    logic [1:0]           in_ready_w;
    logic [DWA*NC-1:0]    out_s;
    logic [DWA*NC-1:0]    out_w;
    logic                 out_valid_s;
    logic                 out_valid_w;
    logic                 busy_s;
    logic                 busy_w;
    logic                 ovf_s;
    logic                 ovf_w;

    int errors = 0;
    int checks = 0;

    int     A [NG][NM];
    int     B [NU][NM];
    longint ms [NC];
    longint mw [NC];
    bit     ovs;
    bit     ovw;

    always #5 clk = ~clk;

    tile_mm_acc #(
        .N_GROUP(NG), .N_UNIT(NU), .N_MUL(NM), .DW_MUL(DWM), .DW_ADD(DWA), .KW(KWB), .SATURATE(1)
    ) dut_sat (
        .clk(clk), .reset(reset), .enable(enable), .start(start), .k_tiles(k_tiles),
        .in_a(in_a), .in_b(in_b), .in_valid(in_valid), .in_ready(in_ready_s),
        .out(out_s), .out_valid(out_valid_s), .out_ready(out_ready), .busy(busy_s), .ovf(ovf_s)
    );

    tile_mm_acc #(
        .N_GROUP(NG), .N_UNIT(NU), .N_MUL(NM), .DW_MUL(DWM), .DW_ADD(DWA), .KW(KWB), .SATURATE(0)
    ) dut_wrap (
        .clk(clk), .reset(reset), .enable(enable), .start(start), .k_tiles(k_tiles),
        .in_a(in_a), .in_b(in_b), .in_valid(in_valid), .in_ready(in_ready_w),
        .out(out_w), .out_valid(out_valid_w), .out_ready(out_ready), .busy(busy_w), .ovf(ovf_w)
    );

    function automatic int rnd_elem();
        if ($urandom_range(0, 7) == 0) return -128;
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    function automatic void fill(input bit rnd, input int ca, input int cb);
        for (int g = 0; g < int'(NG); g++)
            for (int m = 0; m < int'(NM); m++) A[g][m] = rnd ? rnd_elem() : ca;
        for (int u = 0; u < int'(NU); u++)
            for (int m = 0; m < int'(NM); m++) B[u][m] = rnd ? rnd_elem() : cb;
    endfunction

    function automatic logic [DWM*NM*NG-1:0] pack_a();
        logic [DWM*NM*NG-1:0] v = '0;
        for (int g = 0; g < int'(NG); g++)
            for (int m = 0; m < int'(NM); m++) v[(g*NM+m)*DWM +: DWM] = DWM'(A[g][m]);
        return v;
    endfunction

    function automatic logic [DWM*NM*NU-1:0] pack_b();
        logic [DWM*NM*NU-1:0] v = '0;
        for (int u = 0; u < int'(NU); u++)
            for (int m = 0; m < int'(NM); m++) v[(u*NM+m)*DWM +: DWM] = DWM'(B[u][m]);
        return v;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < int'(NC); i++) begin
            ms[i] = 0;
            mw[i] = 0;
        end
        ovs = 1'b0;
        ovw = 1'b0;
    endfunction

    // One K-tile: exact dot products, then clamp or wrap into 16-bit signed range.
    function automatic void model_tile();
        longint d;
        longint x;
        longint y;
        int     idx;
        for (int g = 0; g < int'(NG); g++) begin
            for (int u = 0; u < int'(NU); u++) begin
                d = 0;
                for (int m = 0; m < int'(NM); m++) d += longint'(A[g][m]) * longint'(B[u][m]);
                idx = g * NU + u;
                x = ms[idx] + d;
                if (x > 32767) begin ovs = 1'b1; x = 32767; end
                else if (x < -32768) begin ovs = 1'b1; x = -32768; end
                ms[idx] = x;
                y = mw[idx] + d;
                if (y > 32767 || y < -32768) ovw = 1'b1;
                y = y & 64'hFFFF;
                if (y >= 32768) y = y - 65536;
                mw[idx] = y;
            end
        end
    endfunction

    function automatic logic [DWA*NC-1:0] exp_vec(input bit sat);
        logic [DWA*NC-1:0] v = '0;
        for (int i = 0; i < int'(NC); i++) v[i*DWA +: DWA] = sat ? DWA'(ms[i]) : DWA'(mw[i]);
        return v;
    endfunction

    task automatic do_start(input int k);
        @(negedge clk);
        start   = 1'b1;
        k_tiles = KWB'(k);
        @(negedge clk);
        start = 1'b0;
        model_clear();
    endtask

    task automatic accept();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // Present k tile pairs back to back (optional idle gaps); returns at the negedge after the last capture.
    task automatic stream(input int k, input bit rnd, input int ca, input int cb, input bit gaps);
        int n;
        for (int t = 0; t < k; t++) begin
            fill(rnd, ca, cb);
            in_a     = pack_a();
            in_b     = pack_b();
            in_valid = 2'b11;
            #1;
            n = 0;
            while (in_ready_s !== 2'b11 && n < 16) begin
                @(negedge clk);
                #1;
                n++;
            end
            checks++;
            if (n >= 16) begin
                errors++;
                $display("FAIL stream_ready got=%b exp=11", in_ready_s);
            end
            model_tile();
            @(negedge clk);
            in_valid = 2'b00;
            if (gaps && t < k - 1) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({out_valid_s, busy_s, in_ready_s, ovf_s, out_valid_w, busy_w, in_ready_w, ovf_w} !== 10'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=0",
                     {out_valid_s, busy_s, in_ready_s, ovf_s, out_valid_w, busy_w, in_ready_w, ovf_w});
        end
        checks++;
        if (out_s !== '0 || out_w !== '0) begin
            errors++;
            $display("FAIL reset_out got=%h/%h exp=0", out_s, out_w);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (busy_s !== 1'b0 || in_ready_s !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_reset busy=%b ready=%b exp=0/00", busy_s, in_ready_s);
        end
    endtask

    task automatic test_basic();
        do_start(1);
        #1;
        checks++;
        if (busy_s !== 1'b1 || in_ready_s !== 2'b11) begin
            errors++;
            $display("FAIL basic_accum busy=%b ready=%b exp=1/11", busy_s, in_ready_s);
        end
        stream(1, 1'b0, 1, 2, 1'b0);
        #1;
        checks++;
        if (out_valid_s !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_valid got=%b exp=0", out_valid_s);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid_s !== 1'b1 || out_valid_w !== 1'b1) begin
            errors++;
            $display("FAIL basic_valid got=%b/%b exp=1", out_valid_s, out_valid_w);
        end
        checks++;
        if (out_s !== {NC{16'd8}} || out_w !== {NC{16'd8}} || ovf_s !== 1'b0) begin
            errors++;
            $display("FAIL basic_out got=%h/%h ovf=%b exp=%h ovf=0", out_s, out_w, ovf_s, {NC{16'd8}});
        end
        accept();
        #1;
        checks++;
        if (busy_s !== 1'b0 || out_valid_s !== 1'b0 || out_s !== {NC{16'd8}}) begin
            errors++;
            $display("FAIL basic_to_idle busy=%b valid=%b out=%h exp=0/0/%h", busy_s, out_valid_s, out_s, {NC{16'd8}});
        end
    endtask

    task automatic test_skew();
        do_start(1);
        fill(1'b1, 0, 0);
        model_tile();
        in_a     = pack_a();
        in_b     = pack_b();
        in_valid = 2'b01;
        #1;
        checks++;
        if (in_ready_s !== 2'b11) begin
            errors++;
            $display("FAIL skew_c0_ready got=%b exp=11", in_ready_s);
        end
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            in_valid = (c == 3) ? 2'b10 : 2'b00;
            #1;
            checks++;
            if (in_ready_s[0] !== 1'b0 || (c == 3 && in_ready_s[1] !== 1'b1)) begin
                errors++;
                $display("FAIL skew_ready_c%0d got=%b exp=%s", c, in_ready_s, (c == 3) ? "10" : "x0");
            end
        end
        @(negedge clk);
        in_valid = 2'b00;
        #1;
        checks++;
        if (out_valid_s !== 1'b0) begin
            errors++;
            $display("FAIL skew_early_valid got=%b exp=0", out_valid_s);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid_s !== 1'b1 || out_s !== exp_vec(1'b1) || out_w !== exp_vec(1'b0)) begin
            errors++;
            $display("FAIL skew_result valid=%b got=%h/%h exp=%h/%h",
                     out_valid_s, out_s, out_w, exp_vec(1'b1), exp_vec(1'b0));
        end
        accept();
    endtask

    task automatic test_overflow();
        do_start(3);
        stream(3, 1'b0, 127, 127, 1'b0);
        @(negedge clk);
        #1;
        checks++;
        if (out_valid_s !== 1'b1 || out_s !== {NC{16'h7FFF}} || ovf_s !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sat valid=%b got=%h ovf=%b exp=%h ovf=1", out_valid_s, out_s, ovf_s, {NC{16'h7FFF}});
        end
        checks++;
        if (out_w !== {NC{16'hF40C}} || ovf_w !== 1'b1) begin
            errors++;
            $display("FAIL ovf_wrap got=%h ovf=%b exp=%h ovf=1", out_w, ovf_w, {NC{16'hF40C}});
        end
        accept();
    endtask

    task automatic test_hold();
        logic [DWA*NC-1:0] es;
        logic [DWA*NC-1:0] ew;
        do_start(2);
        stream(2, 1'b1, 0, 0, 1'b0);
        es = exp_vec(1'b1);
        ew = exp_vec(1'b0);
        @(negedge clk);
        fill(1'b1, 0, 0);
        in_a     = pack_a();
        in_b     = pack_b();
        in_valid = 2'b11;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (out_valid_s !== 1'b1 || out_s !== es || out_w !== ew || in_ready_s !== 2'b00 ||
                in_ready_w !== 2'b00 || ovf_s !== ovs || ovf_w !== ovw) begin
                errors++;
                $display("FAIL hold_c%0d valid=%b out=%h/%h ready=%b ovf=%b/%b exp=1 %h/%h 00 %b/%b",
                         c, out_valid_s, out_s, out_w, in_ready_s, ovf_s, ovf_w, es, ew, ovs, ovw);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        start     = 1'b1;
        k_tiles   = KWB'(1);
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        in_valid  = 2'b00;
        model_clear();
        #1;
        checks++;
        if (busy_s !== 1'b1 || out_valid_s !== 1'b0 || out_s !== '0 || out_w !== '0 ||
            ovf_s !== 1'b0 || in_ready_s !== 2'b11) begin
            errors++;
            $display("FAIL hold_restart busy=%b valid=%b out=%h/%h ovf=%b ready=%b exp=1 0 0 0 11",
                     busy_s, out_valid_s, out_s, out_w, ovf_s, in_ready_s);
        end
        stream(1, 1'b1, 0, 0, 1'b0);
        @(negedge clk);
        #1;
        checks++;
        if (out_valid_s !== 1'b1 || out_s !== exp_vec(1'b1) || out_w !== exp_vec(1'b0)) begin
            errors++;
            $display("FAIL hold_next_result valid=%b got=%h/%h exp=%h/%h",
                     out_valid_s, out_s, out_w, exp_vec(1'b1), exp_vec(1'b0));
        end
        accept();
    endtask

    task automatic test_reset_mid();
        do_start(4);
        stream(2, 1'b1, 0, 0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (out_s !== '0 || out_w !== '0 || out_valid_s !== 1'b0 || busy_s !== 1'b0 ||
            in_ready_s !== 2'b00 || ovf_s !== 1'b0 || ovf_w !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid out=%h/%h valid=%b busy=%b ready=%b ovf=%b/%b exp=all 0",
                     out_s, out_w, out_valid_s, busy_s, in_ready_s, ovf_s, ovf_w);
        end
        do_start(1);
        stream(1, 1'b1, 0, 0, 1'b0);
        @(negedge clk);
        #1;
        checks++;
        if (out_valid_s !== 1'b1 || out_s !== exp_vec(1'b1) || out_w !== exp_vec(1'b0) ||
            ovf_s !== ovs || ovf_w !== ovw) begin
            errors++;
            $display("FAIL reset_fresh valid=%b got=%h/%h ovf=%b/%b exp=%h/%h ovf=%b/%b",
                     out_valid_s, out_s, out_w, ovf_s, ovf_w, exp_vec(1'b1), exp_vec(1'b0), ovs, ovw);
        end
        accept();
    endtask

    task automatic test_enable();
        do_start(3);
        fill(1'b1, 0, 0);
        model_tile();
        in_a     = pack_a();
        in_b     = pack_b();
        in_valid = 2'b11;
        @(negedge clk);
        enable = 1'b0;
        fill(1'b1, 0, 0);
        in_a = pack_a();
        in_b = pack_b();
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (in_ready_s !== 2'b00 || out_s !== '0 || busy_s !== 1'b1) begin
                errors++;
                $display("FAIL enable_low_c%0d ready=%b out=%h busy=%b exp=00 0 1", c, in_ready_s, out_s, busy_s);
            end
            @(negedge clk);
        end
        enable = 1'b1;
        model_tile();
        #1;
        checks++;
        if (in_ready_s !== 2'b11) begin
            errors++;
            $display("FAIL enable_resume_ready got=%b exp=11", in_ready_s);
        end
        @(negedge clk);
        stream(1, 1'b1, 0, 0, 1'b0);
        @(negedge clk);
        #1;
        checks++;
        if (out_valid_s !== 1'b1 || out_s !== exp_vec(1'b1) || out_w !== exp_vec(1'b0)) begin
            errors++;
            $display("FAIL enable_result valid=%b got=%h/%h exp=%h/%h",
                     out_valid_s, out_s, out_w, exp_vec(1'b1), exp_vec(1'b0));
        end
        accept();
    endtask

    task automatic test_k_zero();
        do_start(0);
        stream(1, 1'b1, 0, 0, 1'b0);
        @(negedge clk);
        #1;
        checks++;
        if (out_valid_s !== 1'b1 || out_s !== exp_vec(1'b1) || out_w !== exp_vec(1'b0)) begin
            errors++;
            $display("FAIL k_zero valid=%b got=%h/%h exp=%h/%h",
                     out_valid_s, out_s, out_w, exp_vec(1'b1), exp_vec(1'b0));
        end
        accept();
    endtask

    task automatic test_back_to_back();
        int k;
        k = int'($urandom_range(1, 4));
        do_start(k);
        for (int s = 0; s < 12; s++) begin
            stream(k, 1'b1, 0, 0, 1'b1);
            @(negedge clk);
            #1;
            checks++;
            if (out_valid_s !== 1'b1 || out_s !== exp_vec(1'b1) || ovf_s !== ovs) begin
                errors++;
                $display("FAIL b2b_sat_s%0d k=%0d valid=%b got=%h ovf=%b exp=%h ovf=%b",
                         s, k, out_valid_s, out_s, ovf_s, exp_vec(1'b1), ovs);
            end
            checks++;
            if (out_w !== exp_vec(1'b0) || ovf_w !== ovw) begin
                errors++;
                $display("FAIL b2b_wrap_s%0d k=%0d got=%h ovf=%b exp=%h ovf=%b",
                         s, k, out_w, ovf_w, exp_vec(1'b0), ovw);
            end
            k = int'($urandom_range(1, 4));
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                out_ready = 1'b1;
                start     = 1'b1;
                k_tiles   = KWB'(k);
                @(negedge clk);
                out_ready = 1'b0;
                start     = 1'b0;
                model_clear();
            end else begin
                accept();
                do_start(k);
            end
        end
        stream(k, 1'b1, 0, 0, 1'b0);
        @(negedge clk);
        accept();
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        k_tiles   = '0;
        in_a      = '0;
        in_b      = '0;
        in_valid  = 2'b00;
        test_reset();
        test_basic();
        test_skew();
        test_overflow();
        test_hold();
        test_reset_mid();
        test_enable();
        test_k_zero();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t exp=finish earlier", $time);
        $fatal(1);
    end

endmodule
